// File: rtl/serial_sub_if.sv
// Word-level handshake bundle for the bit-serial subtractor.
interface serial_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             z;
  logic             z_valid;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a_in, b_in,
    input  busy, z, z_valid, done, diff, borrow_out
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, z, z_valid, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_sub_fsm.sv
// Bit-serial subtractor: diff = a_in - b_in mod 2^WIDTH, processed LSB first
// through a two-state borrow FSM, one bit per clock.
module serial_sub_fsm #(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  serial_sub_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic {Br0, Br1} borrow_e;

  state_e           state_q;
  borrow_e          borrow_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic             z_q;
  logic             z_valid_q;
  logic             done_q;
  logic             busy_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;

  logic    a_bit;
  logic    b_bit;
  logic    d_bit;
  borrow_e borrow_d;
  logic    last_bit;

  assign a_bit    = a_sh_q[0];
  assign b_bit    = b_sh_q[0];
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // Borrow FSM: difference bit and next borrow state from the current LSBs.
  always_comb begin
    d_bit    = 1'b0;
    borrow_d = Br0;
    unique case (borrow_q)
      Br0: begin
        d_bit    = a_bit ^ b_bit;
        borrow_d = (~a_bit & b_bit) ? Br1 : Br0;
      end
      Br1: begin
        d_bit    = ~(a_bit ^ b_bit);
        borrow_d = (a_bit & ~b_bit) ? Br0 : Br1;
      end
      default: begin
        d_bit    = 1'b0;
        borrow_d = Br0;
      end
    endcase
  end

  // Control FSM with registered outputs; the last RUN edge also publishes the word result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      borrow_q     <= Br0;
      cnt_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_sh_q     <= '0;
      z_q          <= 1'b0;
      z_valid_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      // z_valid and done are set only by RUN edges, so both drop on any other edge.
      z_valid_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q  <= StRun;
            busy_q   <= 1'b1;
            a_sh_q   <= bus.a_in;
            b_sh_q   <= bus.b_in;
            res_sh_q <= '0;
            borrow_q <= Br0;
            cnt_q    <= '0;
          end
        end
        StRun: begin
          z_q       <= d_bit;
          z_valid_q <= 1'b1;
          a_sh_q    <= a_sh_q >> 1;
          b_sh_q    <= b_sh_q >> 1;
          res_sh_q  <= {d_bit, res_sh_q[WIDTH-1:1]};
          borrow_q  <= borrow_d;
          cnt_q     <= cnt_q + 1'b1;
          if (last_bit) begin
            state_q      <= StDone;
            done_q       <= 1'b1;
            diff_q       <= {d_bit, res_sh_q[WIDTH-1:1]};
            borrow_out_q <= (borrow_d == Br1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          borrow_q <= Br0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.z          = z_q;
  assign bus.z_valid    = z_valid_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
endmodule

// File: tb/tb_serial_sub_fsm.sv
// Directed and random checks of serial_sub_fsm at WIDTH=8 and WIDTH=16.
module tb_serial_sub_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start8 = 1'b0;
  logic start16 = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  exp8 = '0;
  logic        expb8 = 1'b0;
  logic [15:0] exp16 = '0;
  logic        expb16 = 1'b0;

  serial_sub_if #(.WIDTH(8))  bus8 ();
  serial_sub_if #(.WIDTH(16)) bus16 ();

  assign bus8.start  = start8;
  assign bus8.a_in   = op_a[7:0];
  assign bus8.b_in   = op_b[7:0];
  assign bus16.start = start16;
  assign bus16.a_in  = op_a;
  assign bus16.b_in  = op_b;

  serial_sub_fsm #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_sub_fsm #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Serial stream collectors: z bits shift in LSB-first, so after WIDTH bits they equal diff.
  logic [7:0]  zb8 = '0;
  logic [15:0] zb16 = '0;
  int zn8 = 0;
  int zn16 = 0;

  always @(negedge clk) begin
    if (rst) begin
      zn8 = 0;
    end else begin
      if (bus8.z_valid) begin
        zb8 = {bus8.z, zb8[7:1]};
        zn8++;
      end
      if (bus8.done) begin
        check("diff8_ref", {24'h0, bus8.diff}, {24'h0, exp8});
        check("borrow8_ref", {31'h0, bus8.borrow_out}, {31'h0, expb8});
        check("zstream8", {24'h0, zb8}, {24'h0, exp8});
        check("zcount8", zn8, 8);
        zn8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      zn16 = 0;
    end else begin
      if (bus16.z_valid) begin
        zb16 = {bus16.z, zb16[15:1]};
        zn16++;
      end
      if (bus16.done) begin
        check("diff16_ref", {16'h0, bus16.diff}, {16'h0, exp16});
        check("borrow16_ref", {31'h0, bus16.borrow_out}, {31'h0, expb16});
        check("zstream16", {16'h0, zb16}, {16'h0, exp16});
        check("zcount16", zn16, 16);
        zn16 = 0;
      end
    end
  end

  // One operation on both DUTs; k counts edges after the accepting edge.
  task automatic go(input logic [15:0] a, input logic [15:0] b);
    int k;
    @(negedge clk);
    op_a = a;
    op_b = b;
    start8 = 1'b1;
    start16 = 1'b1;
    exp8 = a[7:0] - b[7:0];
    expb8 = (a[7:0] < b[7:0]);
    exp16 = a - b;
    expb16 = (a < b);
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
    op_a = ~a;
    op_b = ~b;
    k = 0;
    while (!bus8.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("latency8", k, 8);
    @(negedge clk);
    k++;
    check("done_pulse8", {31'h0, bus8.done}, 0);
    check("zvalid_off8", {31'h0, bus8.z_valid}, 0);
    while (!bus16.done && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("latency16", k, 16);
    @(negedge clk);
    check("done_pulse16", {31'h0, bus16.done}, 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int k;
    int dones;
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vecs[6] = '{8'h01, 8'h80, 8'h81, 1'b1};
    vecs[7] = '{8'hAA, 8'h55, 8'h55, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, bus8.busy}, 0);
    check("rst_z", {31'h0, bus8.z}, 0);
    check("rst_zvalid", {31'h0, bus8.z_valid}, 0);
    check("rst_done", {31'h0, bus8.done}, 0);
    check("rst_diff", {24'h0, bus8.diff}, 0);
    check("rst_borrow", {31'h0, bus8.borrow_out}, 0);
    check("rst_busy16", {31'h0, bus16.busy}, 0);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      go({8'h00, vecs[i].a}, {8'h00, vecs[i].b});
      check("tbl_diff", {24'h0, bus8.diff}, {24'h0, vecs[i].d});
      check("tbl_borrow", {31'h0, bus8.borrow_out}, {31'h0, vecs[i].br});
      check("tbl_idle", {31'h0, bus8.busy}, 0);
    end

    // start while busy is ignored; then back-to-back acceptance after DONE
    @(negedge clk);
    op_a = 16'h0030;
    op_b = 16'h0011;
    start8 = 1'b1;
    exp8 = 8'h1F;
    expb8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    check("run_busy", {31'h0, bus8.busy}, 1);
    check("run_zvalid_first", {31'h0, bus8.z_valid}, 0);
    repeat (2) begin
      @(negedge clk);
      k++;
    end
    op_a = 16'h00FF;
    op_b = 16'h0000;
    start8 = 1'b1;
    @(negedge clk);
    k++;
    start8 = 1'b0;
    while (!bus8.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("ign_latency", k, 8);
    check("ign_diff", {24'h0, bus8.diff}, 32'h1F);
    op_a = 16'h0040;
    op_b = 16'h0041;
    start8 = 1'b1;
    @(negedge clk);
    check("b2b_idle", {31'h0, bus8.busy}, 0);
    exp8 = 8'hFF;
    expb8 = 1'b1;
    @(negedge clk);
    check("b2b_accept", {31'h0, bus8.busy}, 1);
    start8 = 1'b0;
    k = 0;
    while (!bus8.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("b2b_latency", k, 8);
    check("b2b_diff", {24'h0, bus8.diff}, 32'hFF);
    check("b2b_borrow", {31'h0, bus8.borrow_out}, 1);
    repeat (2) @(negedge clk);

    // Reset in the middle of an operation, as bit 4 is about to be processed
    op_a = 16'h0080;
    op_b = 16'h0001;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {31'h0, bus8.busy}, 0);
    check("mid_rst_z", {31'h0, bus8.z}, 0);
    check("mid_rst_zvalid", {31'h0, bus8.z_valid}, 0);
    check("mid_rst_done", {31'h0, bus8.done}, 0);
    check("mid_rst_diff", {24'h0, bus8.diff}, 0);
    check("mid_rst_borrow", {31'h0, bus8.borrow_out}, 0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus8.done) dones++;
    end
    check("mid_rst_no_done", dones, 0);
    go(16'h0080, 16'h0001);
    check("post_rst_diff", {24'h0, bus8.diff}, 32'h7F);
    check("post_rst_borrow", {31'h0, bus8.borrow_out}, 0);
    check("post_rst_diff16", {16'h0, bus16.diff}, 32'h7F);

    // Random sweep, checked against the reference subtraction by the collectors
    for (int i = 0; i < 1000; i++) begin
      go(16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
